// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and widths for the UART transmit path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

  localparam int UART_BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2,
    GAP  = 2'd3
  } tx_feeder_state_t;

endpackage

`default_nettype wire

// File: rtl/uart_byte_fifo.sv
// ============================================================================
// Module      : uart_byte_fifo
// Description : Circular byte FIFO with registered status and a sticky
//               overflow flag for pushes dropped while full.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_byte_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [UART_BYTE_W-1:0]   i_wr_data,
  input  logic                     i_pop,
  output logic [UART_BYTE_W-1:0]   o_rd_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_overflow
);

  localparam int c_aw = $clog2(DEPTH);
  localparam int c_cw = c_aw + 1;
  localparam logic [c_cw-1:0] c_depth = c_cw'(DEPTH);

  logic [UART_BYTE_W-1:0] r_mem [DEPTH];
  logic [c_aw-1:0]        r_wr_ptr;
  logic [c_aw-1:0]        r_rd_ptr;
  logic [c_cw-1:0]        r_count;
  logic [c_cw-1:0]        w_count_nxt;
  logic                   r_full;
  logic                   r_empty;
  logic                   r_overflow;
  logic                   w_do_push;
  logic                   w_do_pop;

  // Acceptance looks only at the registered full flag, so a push into a
  // full FIFO is dropped even when a pop frees a slot in the same cycle.
  assign w_do_push = i_push && !r_full;
  assign w_do_pop  = i_pop && !r_empty;

  always_comb begin
    w_count_nxt = r_count;
    if (w_do_push && !w_do_pop) begin
      w_count_nxt = r_count + 1'b1;
    end else if (!w_do_push && w_do_pop) begin
      w_count_nxt = r_count - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_overflow <= 1'b0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == c_depth);
      r_empty <= (w_count_nxt == '0);
      if (i_push && r_full) begin
        r_overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  assign o_rd_data  = r_mem[r_rd_ptr];
  assign o_full     = r_full;
  assign o_empty    = r_empty;
  assign o_count    = r_count;
  assign o_overflow = r_overflow;

endmodule

`default_nettype wire

// File: rtl/uart_tx_feeder.sv
// ============================================================================
// Module      : uart_tx_feeder
// Description : Buffered byte source driving the uart_tx start/done
//               handshake. Define UART_TX_FEEDER_GAP_EN to insert
//               GAP_CYCLES idle cycles between frames.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int GAP_CYCLES = 16
) (
  input  logic                    i_Clock,
  input  logic                    i_Reset,
  input  logic                    i_Wr_DV,
  input  logic [UART_BYTE_W-1:0]  i_Wr_Byte,
  output logic                    o_Full,
  output logic                    o_Empty,
  output logic [$clog2(DEPTH):0]  o_Count,
  output logic                    o_Overflow,
  output logic                    o_Tx_DV,
  output logic [UART_BYTE_W-1:0]  o_Tx_Byte,
  input  logic                    i_Tx_Done,
  output logic                    o_Busy
);

  if (GAP_CYCLES < 1) begin : g_gap_cycles_check
    $error("uart_tx_feeder: GAP_CYCLES must be >= 1");
  end

  tx_feeder_state_t        r_state;
  tx_feeder_state_t        w_state_nxt;
  logic                    w_pop;
  logic                    w_fifo_empty;
  logic [UART_BYTE_W-1:0]  w_fifo_head;
  logic [UART_BYTE_W-1:0]  r_tx_byte;

  uart_byte_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (i_Clock),
    .rst        (i_Reset),
    .i_push     (i_Wr_DV),
    .i_wr_data  (i_Wr_Byte),
    .i_pop      (w_pop),
    .o_rd_data  (w_fifo_head),
    .o_full     (o_Full),
    .o_empty    (w_fifo_empty),
    .o_count    (o_Count),
    .o_overflow (o_Overflow)
  );

  assign o_Empty = w_fifo_empty;

`ifdef UART_TX_FEEDER_GAP_EN
  localparam int c_gap_w = $clog2(GAP_CYCLES + 1);
  localparam logic [c_gap_w-1:0] c_gap_last = c_gap_w'(GAP_CYCLES - 1);

  logic [c_gap_w-1:0] r_gap_cnt;
  logic               w_gap_done;

  assign w_gap_done = (r_gap_cnt == c_gap_last);

  // Counter idles at zero outside GAP so each gap starts a fresh count.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_gap_cnt <= '0;
    end else if (r_state != GAP) begin
      r_gap_cnt <= '0;
    end else begin
      r_gap_cnt <= r_gap_cnt + 1'b1;
    end
  end
`endif

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (!w_fifo_empty) begin
          w_state_nxt = SEND;
        end
      end
      SEND: begin
        w_state_nxt = WAIT;
      end
      WAIT: begin
        if (i_Tx_Done) begin
`ifdef UART_TX_FEEDER_GAP_EN
          w_state_nxt = GAP;
`else
          w_state_nxt = IDLE;
`endif
        end
      end
`ifdef UART_TX_FEEDER_GAP_EN
      GAP: begin
        if (w_gap_done) begin
          w_state_nxt = IDLE;
        end
      end
`endif
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    w_pop   = 1'b0;
    o_Tx_DV = 1'b0;
    o_Busy  = 1'b1;
    case (r_state)
      IDLE: begin
        w_pop  = !w_fifo_empty;
        o_Busy = 1'b0;
      end
      SEND: begin
        o_Tx_DV = 1'b1;
      end
      default: begin
        o_Busy = 1'b1;
      end
    endcase
  end

  // The byte register only loads on a pop, keeping it stable for uart_tx.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_tx_byte <= '0;
    end else if (w_pop) begin
      r_tx_byte <= w_fifo_head;
    end
  end

  assign o_Tx_Byte = r_tx_byte;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_feeder.sv
// ============================================================================
// Module      : tb_uart_tx_feeder
// Description : Scoreboard bench for uart_tx_feeder with a uart_tx stand-in.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_feeder;

  localparam int DEPTH      = 8;
  localparam int GAP_CYCLES = 16;
  localparam int DONE_LAT   = 20;
`ifdef UART_TX_FEEDER_GAP_EN
  localparam int EXP_GAP_DELTA = GAP_CYCLES + 1;
`else
  localparam int EXP_GAP_DELTA = 1;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_dv = 1'b0;
  logic [7:0] wr_byte = 8'h00;
  logic       full, empty, ovf, tx_dv, busy;
  logic [3:0] count;
  logic [7:0] tx_byte;
  logic       model_done = 1'b0;
  logic       main_done = 1'b0;
  logic       tx_done;
  logic       auto_done = 1'b0;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  int last_push_edge = 0;
  logic [7:0] exp_q[$];
  int dv_cycles[$];
  int done_edges[$];

  assign tx_done = model_done | main_done;

  uart_tx_feeder #(
    .DEPTH      (DEPTH),
    .GAP_CYCLES (GAP_CYCLES)
  ) dut (
    .i_Clock    (clk),
    .i_Reset    (rst),
    .i_Wr_DV    (wr_dv),
    .i_Wr_Byte  (wr_byte),
    .o_Full     (full),
    .o_Empty    (empty),
    .o_Count    (count),
    .o_Overflow (ovf),
    .o_Tx_DV    (tx_dv),
    .o_Tx_Byte  (tx_byte),
    .i_Tx_Done  (tx_done),
    .o_Busy     (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_count"}, 32'(count), 0);
    chk({tag, "_empty"}, 32'(empty), 1);
    chk({tag, "_full"},  32'(full), 0);
    chk({tag, "_ovf"},   32'(ovf), 0);
    chk({tag, "_tx_dv"}, 32'(tx_dv), 0);
    chk({tag, "_byte"},  32'(tx_byte), 0);
    chk({tag, "_busy"},  32'(busy), 0);
  endtask

  // Call at a negedge; returns at the following negedge.
  task automatic push(input logic [7:0] b, input bit accept);
    wr_dv = 1'b1;
    wr_byte = b;
    last_push_edge = cyc + 1;
    if (accept) exp_q.push_back(b);
    @(negedge clk);
    wr_dv = 1'b0;
  endtask

  task automatic pulse_done();
    main_done = 1'b1;
    @(negedge clk);
    main_done = 1'b0;
  endtask

  task automatic wait_dv(input int n, input int budget, input string name);
    for (int i = 0; i < budget && dv_cycles.size() < n; i++) @(negedge clk);
    chk(name, 32'(dv_cycles.size() >= n), 1);
  endtask

  task automatic wait_drain(input int budget, input string name);
    for (int i = 0; i < budget && !(empty && !busy && exp_q.size() == 0); i++) @(negedge clk);
    chk(name, 32'(empty && !busy && exp_q.size() == 0), 1);
  endtask

  // uart_tx stand-in: answers each start pulse with a done pulse.
  initial begin : uart_model
    forever begin
      @(negedge clk);
      if (!rst && auto_done && tx_dv) begin
        repeat (DONE_LAT - 1) @(negedge clk);
        if (!rst) begin
          model_done = 1'b1;
          done_edges.push_back(cyc + 1);
          @(negedge clk);
          model_done = 1'b0;
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every start pulse.
  initial begin : monitor
    logic       prev_dv;
    logic       have_held;
    logic [7:0] held;
    logic [7:0] e;
    prev_dv = 1'b0;
    have_held = 1'b0;
    held = 8'h00;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_dv = 1'b0;
        have_held = 1'b0;
      end else begin
        if (tx_dv) begin
          dv_cycles.push_back(cyc);
          chk("dv_single_cycle", 32'(prev_dv), 0);
          chk("dv_has_expected", 32'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("tx_byte_order", 32'(tx_byte), 32'(e));
          end
          held = tx_byte;
          have_held = 1'b1;
        end else if (busy && have_held) begin
          chk("tx_byte_stable", 32'(tx_byte), 32'(held));
        end
        prev_dv = tx_dv;
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int         p_edge;
    int         b_dv;
    int         b_done;
    int         seq[$];
    logic [3:0] prev_cnt;

    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst = 1'b0;
    @(negedge clk);

    // Single byte: pulse one edge after the push, then held in WAIT.
    push(8'h41, 1'b1);
    p_edge = last_push_edge;
    wait_dv(1, 20, "t1_dv_seen");
    chk("t1_dv_latency", 32'(dv_cycles.size() > 0 ? dv_cycles[0] - p_edge : -1), 1);
    repeat (30) @(negedge clk);
    chk("t1_no_second_pulse", 32'(dv_cycles.size()), 1);
    chk("t1_byte", 32'(tx_byte), 32'h41);
    chk("t1_busy", 32'(busy), 1);

    // Three bytes queued behind the stalled frame, then drained.
    push(8'h01, 1'b1);
    push(8'h41, 1'b1);
    push(8'h7E, 1'b1);
    chk("t2_count_queued", 32'(count), 3);
    auto_done = 1'b1;
    pulse_done();
    prev_cnt = count;
    for (int i = 0; i < 300 && !(empty && !busy && exp_q.size() == 0); i++) begin
      @(negedge clk);
      if (count != prev_cnt) seq.push_back(int'(count));
      prev_cnt = count;
    end
    chk("t2_count_steps", 32'(seq.size()), 3);
    chk("t2_count_a", 32'(seq.size() > 0 ? seq[0] : 99), 2);
    chk("t2_count_b", 32'(seq.size() > 1 ? seq[1] : 99), 1);
    chk("t2_count_c", 32'(seq.size() > 2 ? seq[2] : 99), 0);
    chk("t2_empty", 32'(empty), 1);
    chk("t2_all_sent", 32'(exp_q.size()), 0);

    // Overflow while stalled in WAIT; pointers wrap.
    auto_done = 1'b0;
    b_dv = dv_cycles.size();
    push(8'hA5, 1'b1);
    wait_dv(b_dv + 1, 20, "t3_dv_seen");
    repeat (2) @(negedge clk);
    for (int i = 0; i < 8; i++) push(8'h10 + 8'(i), 1'b1);
    chk("t3_full", 32'(full), 1);
    chk("t3_count8", 32'(count), 8);
    chk("t3_ovf_clear", 32'(ovf), 0);
    push(8'hFF, 1'b0);
    chk("t3_ovf_set", 32'(ovf), 1);
    chk("t3_count_held", 32'(count), 8);

    // Full FIFO: push lands on the same edge as the pop and is dropped.
    auto_done = 1'b1;
    pulse_done();
    push(8'hEE, 1'b0);
    chk("t4_count7", 32'(count), 7);
    chk("t4_not_full", 32'(full), 0);
    chk("t4_ovf", 32'(ovf), 1);
    wait_drain(600, "t3_drained");

    // Asynchronous reset during WAIT with three bytes queued.
    auto_done = 1'b0;
    b_dv = dv_cycles.size();
    push(8'h20, 1'b1);
    push(8'h21, 1'b1);
    push(8'h22, 1'b1);
    push(8'h23, 1'b1);
    wait_dv(b_dv + 1, 20, "t5_dv_seen");
    repeat (3) @(negedge clk);
    chk("t5_count3", 32'(count), 3);
    #2 rst = 1'b1;
    #1;
    chk_reset_vals("t5_async");
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    b_dv = dv_cycles.size();
    pulse_done();
    repeat (10) @(negedge clk);
    chk("t5_stray_done_ignored", 32'(dv_cycles.size() - b_dv), 0);
    chk("t5_idle", 32'(busy), 0);

    // Frame spacing after done.
    auto_done = 1'b1;
    b_dv = dv_cycles.size();
    b_done = done_edges.size();
    push(8'h5A, 1'b1);
    push(8'hC3, 1'b1);
    wait_dv(b_dv + 2, 200, "t6_two_dv");
    chk("t6_gap_delta",
        32'((dv_cycles.size() > b_dv + 1 && done_edges.size() > b_done)
            ? dv_cycles[b_dv + 1] - done_edges[b_done] : -1),
        32'(EXP_GAP_DELTA));
    wait_drain(200, "t6_drained");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
